hero_write_rx: RTL and testbench
================================

Name: hero_write_rx

Overview:
- Receiving end of the hero write bus: samples a hero_write_t stream (cycle_type IDLE/VALID/DONE, 36-bit wdat, 7-bit sub_def_t, clk_en) and rebuilds beats into transactions.
- Buffers beats in a FIFO and presents them on a ready/valid output with last/abort marking.
- The hero bus has no backpressure, so overflow, illegal cycle types and over-length transactions are detected, aborted cleanly and reported.

Parameters:
- DEPTH, 8, FIFO entries (min 2); one entry is always reserved for an abort marker.
- MAX_BEATS, 16, max beats per transaction, DONE beat included.
- CNT_W, 16, width of txn_cnt.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hero_write  in  46  hero_write_t: cycle_type[45:44], wdat[43:8], another_type_reference[7:1], clk_en[0].
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  consumer accepts head.
- out_dat  out  36  beat wdat (0 for marker).
- out_sub  out  7  beat sub_def_t (0 for marker).
- out_last  out  1  last entry of transaction (DONE beat or marker).
- out_abort  out  1  entry is an abort marker.
- out_beat_idx  out  clog2(MAX_BEATS+1)  0-based beat index; for a marker, the number of beats already stored.
- err_overflow  out  1  one-cycle pulse.
- err_illegal  out  1  one-cycle pulse, cycle_type==3.
- err_too_long  out  1  one-cycle pulse.
- txn_cnt  out  CNT_W  completed (non-aborted) transactions, wraps.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, beat_cnt 0.
- Sampling:
  - A beat is any cycle with clk_en=1 and cycle_type VALID(1) or DONE(2).
  - clk_en=0 cycles and IDLE(0) cycles are ignored entirely.
- Transactions: zero or more VALID beats, then one DONE. A lone DONE from IDLE is a 1-beat transaction.
- FSM states: IDLE, IN_TXN, DROP.
  - IDLE + VALID -> IN_TXN. IDLE + DONE -> IDLE, txn_cnt+1.
  - IN_TXN + VALID -> stay. IN_TXN + DONE -> IDLE, txn_cnt+1.
  - DROP: every beat is discarded; DONE -> IDLE with no txn_cnt change.
- Space rule:
  - A beat may be written only when count < DEPTH-1.
  - count is the registered value, ignoring any same-cycle pop.
- Overflow (beat arrives, count == DEPTH-1):
  - The beat is dropped and err_overflow pulses.
  - In IN_TXN: the abort marker is written into the reserved slot the same cycle (last=1, abort=1, beat_idx=beat_cnt); go to DROP.
  - In IDLE: no marker is written (nothing of this transaction is stored). Go to DROP, or stay in IDLE if the beat was a DONE.
- Too long (beat arrives with beat_cnt == MAX_BEATS):
  - The beat is dropped, err_too_long pulses, marker is written, go to DROP.
  - If overflow also applies, only err_overflow pulses.
- Illegal cycle_type 3 with clk_en=1: err_illegal pulses.
  - In IN_TXN: marker is written, go to IDLE.
  - In IDLE and DROP: no state change.
- beat_cnt increments on each stored beat and clears on entry to IDLE.
- Latency: a beat sampled at edge N shows on out_vld after edge N (next cycle). No bypass.
- Output handshake:
  - Pop on out_vld & out_rdy.
  - out_* hold stable while out_vld=1 and out_rdy=0.
  - Simultaneous push and pop is allowed; count is unchanged.
- FIFO pointers wrap modulo DEPTH. DEPTH need not be a power of 2.
- rst_n asserted mid-transaction: the FIFO is flushed, no marker is emitted, and the next beat starts a new transaction.

Test Plan:
- VALID/VALID/DONE with wdat 0x1, 0x2, 0x3, out_rdy=1 -> three outputs on consecutive cycles starting one cycle after the first beat; idx 0, 1, 2; out_last only on 0x3; txn_cnt=1.
- VALID with clk_en=0, then DONE with clk_en=1 and wdat 0xA -> single entry 0xA, idx 0, last=1.
- DEPTH=4, out_rdy=0, 5 VALID beats + DONE:
  - 3 beats stored, then the marker (abort=1, idx=3); err_overflow pulses once on beat 4.
  - Beat 5 and DONE are discarded; txn_cnt=0; the next transaction is accepted normally after draining.
- VALID, VALID, cycle_type=3 -> 2 beats plus marker (idx=2); err_illegal pulses; a following DONE 0x5 is stored as a 1-beat transaction.
- MAX_BEATS=4, 5 VALID + DONE, out_rdy=1 -> 4 beats (idx 0..3), then marker idx=4; err_too_long pulses once; txn_cnt=0.
- Assert rst_n after 2 beats of a transaction -> out_vld=0 and all outputs 0 immediately; a subsequent DONE 0x7 gives idx 0, last=1.

Source files
------------

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: rebuilds sampled beats into transactions, buffers them
// in a FIFO with last/abort marking, and reports overflow, illegal and over-length errors.
module hero_write_rx #(
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [45:0]      hero_write,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [35:0]      out_dat,
  output logic [6:0]       out_sub,
  output logic             out_last,
  output logic             out_abort,
  output logic [IDX_W-1:0] out_beat_idx,
  output logic             err_overflow,
  output logic             err_illegal,
  output logic             err_too_long,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    CT_IDLE    = 2'd0,
    CT_VALID   = 2'd1,
    CT_DONE    = 2'd2,
    CT_ILLEGAL = 2'd3
  } cycle_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_TXN,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [35:0]      dat;
    logic [6:0]       sub;
    logic             last;
    logic             abort;
    logic [IDX_W-1:0] idx;
  } entry_t;

  cycle_type_e cycle_type;
  logic [35:0] wdat;
  logic [6:0]  sub;
  logic        clk_en;

  assign cycle_type = cycle_type_e'(hero_write[45:44]);
  assign wdat       = hero_write[43:8];
  assign sub        = hero_write[7:1];
  assign clk_en     = hero_write[0];

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_FW-1:0] count;
  entry_t            mem [DEPTH];

  logic   is_beat, is_done, is_illegal, full, push, pop, txn_inc;
  logic   ovf_nxt, ill_nxt, long_nxt;
  entry_t push_entry, beat_entry, marker_entry, head;

  assign is_beat    = clk_en && (cycle_type == CT_VALID || cycle_type == CT_DONE);
  assign is_done    = cycle_type == CT_DONE;
  assign is_illegal = clk_en && (cycle_type == CT_ILLEGAL);
  // The last slot is held back so an abort marker always has room.
  assign full       = count >= CNT_FW'(DEPTH - 1);
  assign pop        = out_vld && out_rdy;

  assign beat_entry   = '{dat: wdat, sub: sub, last: is_done, abort: 1'b0, idx: beat_cnt};
  assign marker_entry = '{dat: '0, sub: '0, last: 1'b1, abort: 1'b1, idx: beat_cnt};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    push         = 1'b0;
    push_entry   = beat_entry;
    txn_inc      = 1'b0;
    ovf_nxt      = 1'b0;
    ill_nxt      = is_illegal;
    long_nxt     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_beat) begin
          if (full) begin
            ovf_nxt = 1'b1;
            if (!is_done) state_nxt = S_DROP;
          end else begin
            push = 1'b1;
            if (is_done) begin
              txn_inc = 1'b1;
            end else begin
              state_nxt    = S_IN_TXN;
              beat_cnt_nxt = beat_cnt + IDX_W'(1);
            end
          end
        end
      end
      S_IN_TXN: begin
        if (is_beat) begin
          if (full || beat_cnt == IDX_W'(MAX_BEATS)) begin
            ovf_nxt    = full;
            long_nxt   = !full;
            push       = 1'b1;
            push_entry = marker_entry;
            state_nxt  = S_DROP;
          end else begin
            push = 1'b1;
            if (is_done) begin
              txn_inc      = 1'b1;
              state_nxt    = S_IDLE;
              beat_cnt_nxt = '0;
            end else begin
              beat_cnt_nxt = beat_cnt + IDX_W'(1);
            end
          end
        end else if (is_illegal) begin
          push         = 1'b1;
          push_entry   = marker_entry;
          state_nxt    = S_IDLE;
          beat_cnt_nxt = '0;
        end
      end
      S_DROP: begin
        if (is_beat && is_done) begin
          state_nxt    = S_IDLE;
          beat_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      txn_cnt      <= '0;
      err_overflow <= 1'b0;
      err_illegal  <= 1'b0;
      err_too_long <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      err_overflow <= ovf_nxt;
      err_illegal  <= ill_nxt;
      err_too_long <= long_nxt;
      if (txn_inc) txn_cnt <= txn_cnt + CNT_W'(1);
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_FW'(1);
      else if (pop && !push) count <= count - CNT_FW'(1);
    end
  end

  // NOTE: storage is not reset; the empty flag gates every read so stale entries never escape.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head         = mem[rd_ptr];
  assign out_vld      = count != '0;
  assign out_dat      = out_vld ? head.dat   : '0;
  assign out_sub      = out_vld ? head.sub   : '0;
  assign out_last     = out_vld ? head.last  : 1'b0;
  assign out_abort    = out_vld ? head.abort : 1'b0;
  assign out_beat_idx = out_vld ? head.idx   : '0;

endmodule

// File: tb/tb_hero_write_rx.sv
// Directed table-driven bench for hero_write_rx (DEPTH=4, MAX_BEATS=4) plus a
// hand-written mid-transaction reset sequence.
module tb_hero_write_rx;

  localparam int DEPTH     = 4;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 16;
  localparam int IDX_W     = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] CI = 2'd0, CV = 2'd1, CD = 2'd2, CX = 2'd3;

  logic             clk;
  logic             rst_n;
  logic [45:0]      hero_write;
  logic             out_vld;
  logic             out_rdy;
  logic [35:0]      out_dat;
  logic [6:0]       out_sub;
  logic             out_last;
  logic             out_abort;
  logic [IDX_W-1:0] out_beat_idx;
  logic             err_overflow;
  logic             err_illegal;
  logic             err_too_long;
  logic [CNT_W-1:0] txn_cnt;

  hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hero_write   (hero_write),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_dat      (out_dat),
    .out_sub      (out_sub),
    .out_last     (out_last),
    .out_abort    (out_abort),
    .out_beat_idx (out_beat_idx),
    .err_overflow (err_overflow),
    .err_illegal  (err_illegal),
    .err_too_long (err_too_long),
    .txn_cnt      (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       ct;
    logic [35:0]      wdat;
    logic             en;
    logic             rdy;
    logic             vld;
    logic [35:0]      dat;
    logic             last;
    logic             abort;
    logic [IDX_W-1:0] idx;
    logic [2:0]       err;   // {overflow, illegal, too_long}
    logic [CNT_W-1:0] txn;
  } vec_t;

  localparam int OBS_W = 1 + 36 + 7 + 1 + 1 + IDX_W + 3 + CNT_W;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  function automatic vec_t v(input logic [1:0] ct, input logic [35:0] wdat, input logic en,
                             input logic rdy, input logic vld, input logic [35:0] dat,
                             input logic last, input logic abort, input logic [IDX_W-1:0] idx,
                             input logic [2:0] err, input logic [CNT_W-1:0] txn);
    vec_t r;
    r = '{ct: ct, wdat: wdat, en: en, rdy: rdy, vld: vld, dat: dat, last: last,
          abort: abort, idx: idx, err: err, txn: txn};
    return r;
  endfunction

  function automatic logic [OBS_W-1:0] observed();
    return {out_vld, out_dat, out_sub, out_last, out_abort, out_beat_idx,
            err_overflow, err_illegal, err_too_long, txn_cnt};
  endfunction

  // Input sub is wdat[6:0]; a stored beat therefore returns dat[6:0], a marker returns 0.
  function automatic logic [OBS_W-1:0] expected(input logic vld, input logic [35:0] dat,
                                                input logic last, input logic abort,
                                                input logic [IDX_W-1:0] idx,
                                                input logic [2:0] err, input logic [CNT_W-1:0] txn);
    return {vld, dat, dat[6:0], last, abort, idx, err, txn};
  endfunction

  task automatic check(input string name, input logic [OBS_W-1:0] act, input logic [OBS_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got vld/dat/sub/last/abort/idx/err/txn=%h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ct, input logic [35:0] wdat, input logic en, input logic rdy);
    hero_write = {ct, wdat, wdat[6:0], en};
    out_rdy    = rdy;
  endtask

  initial begin
    // VALID/VALID/DONE, consumer always ready
    vecs.push_back(v(CV, 36'h1,  1, 1,  1, 36'h1,  0, 0, 0, 3'b000, 0));
    vecs.push_back(v(CV, 36'h2,  1, 1,  1, 36'h2,  0, 0, 1, 3'b000, 0));
    vecs.push_back(v(CD, 36'h3,  1, 1,  1, 36'h3,  1, 0, 2, 3'b000, 1));
    vecs.push_back(v(CI, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 1));
    // clk_en=0 beat ignored, then a lone DONE
    vecs.push_back(v(CV, 36'h9,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 1));
    vecs.push_back(v(CD, 36'hA,  1, 1,  1, 36'hA,  1, 0, 0, 3'b000, 2));
    vecs.push_back(v(CI, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 2));
    // overflow with consumer stalled: 3 beats, marker on beat 4, rest dropped
    vecs.push_back(v(CV, 36'h11, 1, 0,  1, 36'h11, 0, 0, 0, 3'b000, 2));
    vecs.push_back(v(CV, 36'h12, 1, 0,  1, 36'h11, 0, 0, 0, 3'b000, 2));
    vecs.push_back(v(CV, 36'h13, 1, 0,  1, 36'h11, 0, 0, 0, 3'b000, 2));
    vecs.push_back(v(CV, 36'h14, 1, 0,  1, 36'h11, 0, 0, 0, 3'b100, 2));
    vecs.push_back(v(CV, 36'h15, 1, 0,  1, 36'h11, 0, 0, 0, 3'b000, 2));
    vecs.push_back(v(CD, 36'h16, 1, 0,  1, 36'h11, 0, 0, 0, 3'b000, 2));
    vecs.push_back(v(CI, 36'h0,  0, 1,  1, 36'h12, 0, 0, 1, 3'b000, 2));
    vecs.push_back(v(CI, 36'h0,  0, 1,  1, 36'h13, 0, 0, 2, 3'b000, 2));
    vecs.push_back(v(CI, 36'h0,  0, 1,  1, 36'h0,  1, 1, 3, 3'b000, 2));
    vecs.push_back(v(CI, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 2));
    vecs.push_back(v(CD, 36'h17, 1, 1,  1, 36'h17, 1, 0, 0, 3'b000, 3));
    vecs.push_back(v(CI, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 3));
    // illegal cycle type mid-transaction, then a fresh 1-beat transaction
    vecs.push_back(v(CV, 36'h21, 1, 1,  1, 36'h21, 0, 0, 0, 3'b000, 3));
    vecs.push_back(v(CV, 36'h22, 1, 1,  1, 36'h22, 0, 0, 1, 3'b000, 3));
    vecs.push_back(v(CX, 36'h2F, 1, 1,  1, 36'h0,  1, 1, 2, 3'b010, 3));
    vecs.push_back(v(CD, 36'h5,  1, 1,  1, 36'h5,  1, 0, 0, 3'b000, 4));
    vecs.push_back(v(CI, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 4));
    // illegal while idle flags only; with clk_en=0 it is ignored
    vecs.push_back(v(CX, 36'h0,  1, 1,  0, 36'h0,  0, 0, 0, 3'b010, 4));
    vecs.push_back(v(CX, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 4));
    // too long: 4 beats, 5th becomes marker idx 4, DONE dropped
    vecs.push_back(v(CV, 36'h31, 1, 1,  1, 36'h31, 0, 0, 0, 3'b000, 4));
    vecs.push_back(v(CV, 36'h32, 1, 1,  1, 36'h32, 0, 0, 1, 3'b000, 4));
    vecs.push_back(v(CV, 36'h33, 1, 1,  1, 36'h33, 0, 0, 2, 3'b000, 4));
    vecs.push_back(v(CV, 36'h34, 1, 1,  1, 36'h34, 0, 0, 3, 3'b000, 4));
    vecs.push_back(v(CV, 36'h35, 1, 1,  1, 36'h0,  1, 1, 4, 3'b001, 4));
    vecs.push_back(v(CD, 36'h36, 1, 1,  0, 36'h0,  0, 0, 0, 3'b000, 4));
    // overflow on a lone DONE stays in IDLE, so a second one overflows again
    vecs.push_back(v(CD, 36'h41, 1, 0,  1, 36'h41, 1, 0, 0, 3'b000, 5));
    vecs.push_back(v(CD, 36'h42, 1, 0,  1, 36'h41, 1, 0, 0, 3'b000, 6));
    vecs.push_back(v(CD, 36'h43, 1, 0,  1, 36'h41, 1, 0, 0, 3'b000, 7));
    vecs.push_back(v(CD, 36'h44, 1, 0,  1, 36'h41, 1, 0, 0, 3'b100, 7));
    vecs.push_back(v(CD, 36'h45, 1, 0,  1, 36'h41, 1, 0, 0, 3'b100, 7));
    vecs.push_back(v(CI, 36'h0,  0, 1,  1, 36'h42, 1, 0, 0, 3'b000, 7));
    vecs.push_back(v(CI, 36'h0,  0, 1,  1, 36'h43, 1, 0, 0, 3'b000, 7));
    vecs.push_back(v(CI, 36'h0,  0, 1,  0, 36'h0,  0, 0, 0, 3'b000, 7));

    rst_n = 1'b0;
    drive(CI, 36'h0, 1'b0, 1'b0);
    #2;
    check("reset_state", observed(), expected(0, 36'h0, 0, 0, 0, 3'b000, 0));
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ct, vecs[i].wdat, vecs[i].en, vecs[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), observed(),
            expected(vecs[i].vld, vecs[i].dat, vecs[i].last, vecs[i].abort,
                     vecs[i].idx, vecs[i].err, vecs[i].txn));
    end

    // Reset asserted after two beats of a transaction
    drive(CV, 36'h51, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rst_seq_beat0", observed(), expected(1, 36'h51, 0, 0, 0, 3'b000, 7));
    drive(CV, 36'h52, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rst_seq_beat1", observed(), expected(1, 36'h51, 0, 0, 0, 3'b000, 7));
    #2 rst_n = 1'b0;
    #1;
    check("rst_seq_flush", observed(), expected(0, 36'h0, 0, 0, 0, 3'b000, 0));
    drive(CI, 36'h0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    drive(CD, 36'h7, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("rst_seq_new_txn", observed(), expected(1, 36'h7, 1, 0, 0, 3'b000, 1));
    drive(CI, 36'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_seq_drained", observed(), expected(0, 36'h0, 0, 0, 0, 3'b000, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
